// File: rtl/an37_reduce_sched.sv
// Round-robin scheduler sharing one Barrett mod-37 reduction unit among NREQ AN-code requesters.
// Each grant runs IDLE -> REDUCE -> CORRECT -> OUT; results carry q, r, error flag and requester ID.
module an37_reduce_sched #(
    parameter int NREQ   = 4,
    parameter int CW_W   = 18,
    parameter int A      = 37,
    parameter int K      = 16,
    parameter int M      = 1771,
    parameter int Q_W    = 13,
    parameter int R_W    = 6,
    parameter int ECNT_W = 16,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*CW_W-1:0]   req_codeword,
    output logic [NREQ-1:0]        req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic [Q_W-1:0]         out_q,
    output logic [R_W-1:0]         out_r,
    output logic                   out_error,
    input  logic                   err_clr,
    output logic [ECNT_W-1:0]      err_count,
    output logic                   busy
);

    // state   | meaning
    // IDLE    | waiting for a request; grant issued combinationally
    // REDUCE  | Barrett estimate q_t, r_t registered
    // CORRECT | single conditional subtract, result registered
    // OUT     | result held until out_ready
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REDUCE  = 2'd1,
        CORRECT = 2'd2,
        OUT     = 2'd3
    } state_t;

    localparam int P_W = CW_W + K;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [CW_W-1:0]   cw_q;
    logic [Q_W-1:0]    qt_q;
    logic [R_W:0]      rt_q;

    logic [ID_W:0]     cand;
    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic              accept;
    logic [Q_W-1:0]    qt_d;
    logic [R_W:0]      rt_d;
    logic              fix;
    logic [Q_W-1:0]    q_fix;
    logic [R_W-1:0]    r_fix;

    // first valid requester after the pointer, with wrap
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) cand = cand - (ID_W+1)'(NREQ);
            if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_found && !rst) begin
                    req_ready = NREQ'(1) << gnt_idx;
                    accept    = 1'b1;
                    state_d   = REDUCE;
                end
            end
            REDUCE:  state_d = CORRECT;
            CORRECT: state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // full-width product so no bits are lost before the shift
    always_comb begin
        qt_d  = Q_W'((P_W'(cw_q) * P_W'(M)) >> K);
        rt_d  = (R_W+1)'(P_W'(cw_q) - P_W'(qt_d) * P_W'(A));
        fix   = (rt_q >= (R_W+1)'(A));
        q_fix = fix ? qt_q + Q_W'(1) : qt_q;
        r_fix = fix ? R_W'(rt_q - (R_W+1)'(A)) : R_W'(rt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= ID_W'(NREQ - 1);
            id_q      <= '0;
            cw_q      <= '0;
            qt_q      <= '0;
            rt_q      <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_q     <= '0;
            out_r     <= '0;
            out_error <= 1'b0;
            err_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q <= gnt_idx;
                id_q  <= gnt_idx;
                cw_q  <= req_codeword[gnt_idx*CW_W +: CW_W];
            end
            if (state_q == REDUCE) begin
                qt_q <= qt_d;
                rt_q <= rt_d;
            end
            if (state_q == CORRECT) begin
                out_valid <= 1'b1;
                out_id    <= id_q;
                out_q     <= q_fix;
                out_r     <= r_fix;
                out_error <= (r_fix != '0);
            end else if (state_q == OUT && out_ready) begin
                out_valid <= 1'b0;
            end
            // clear has priority over a same-cycle increment
            if (err_clr) begin
                err_count <= '0;
            end else if (state_q == CORRECT && r_fix != '0 && err_count != '1) begin
                err_count <= err_count + ECNT_W'(1);
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_an37_reduce_sched.sv
// Directed bench for an37_reduce_sched: decode values, round-robin order, backpressure,
// error counter clear/saturation and mid-flight reset.
module tb_an37_reduce_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [71:0] req_codeword = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_id;
    logic [12:0] out_q;
    logic [5:0]  out_r;
    logic        out_error;
    logic        err_clr = 1'b0;
    logic [15:0] err_count;
    logic        busy;

    logic [1:0]  s_req_valid = '0;
    logic [35:0] s_req_codeword = '0;
    logic [1:0]  s_req_ready;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic        s_out_id;
    logic [12:0] s_out_q;
    logic [5:0]  s_out_r;
    logic        s_out_error;
    logic        s_err_clr = 1'b0;
    logic [2:0]  s_err_count;
    logic        s_busy;

    int errors = 0;
    int checks = 0;

    an37_reduce_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_codeword(req_codeword),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_q(out_q), .out_r(out_r), .out_error(out_error), .err_clr(err_clr),
        .err_count(err_count), .busy(busy)
    );

    // small counter width so saturation is reachable in a few transactions
    an37_reduce_sched #(.NREQ(2), .ECNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_codeword(s_req_codeword),
        .req_ready(s_req_ready), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_id(s_out_id),
        .out_q(s_out_q), .out_r(s_out_r), .out_error(s_out_error), .err_clr(s_err_clr),
        .err_count(s_err_count), .busy(s_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && dut.state_q == 2'd2) begin
            checks++;
            if (dut.rt_q >= 7'd74) begin
                errors++;
                $display("FAIL rt_bound: r_t=%0d required < 74", dut.rt_q);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0 || out_valid !== 1'b0 || out_id !== 2'd0 || out_q !== 13'd0 ||
            out_r !== 6'd0 || out_error !== 1'b0 || err_count !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b ov=%b id=%0d q=%0d r=%0d e=%b cnt=%0d busy=%b required all 0",
                     req_ready, out_valid, out_id, out_q, out_r, out_error, err_count, busy);
        end
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic run_one(input int id, input logic [17:0] cw, input int exp_q, input int exp_r,
                           input int exp_e, input int exp_cnt, input bit clr_at_correct, input string nm);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << id;
        @(negedge clk);
        req_codeword[id*18 +: 18] = cw;
        req_valid = exp_rdy;
        #1;
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s_grant: req_ready=%b required %b", nm, req_ready, exp_rdy);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (busy !== 1'b1 || req_ready !== 4'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_reduce: busy=%b rdy=%b ov=%b required 1 0000 0", nm, busy, req_ready, out_valid);
        end
        @(negedge clk);
        if (clr_at_correct) err_clr = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency: out_valid=%b required 0 in CORRECT", nm, out_valid);
        end
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'(id) || out_q !== 13'(exp_q) || out_r !== 6'(exp_r) ||
            out_error !== 1'(exp_e) || err_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL %s_result: ov=%b id=%0d q=%0d r=%0d e=%b cnt=%0d required 1 %0d %0d %0d %0d %0d",
                     nm, out_valid, out_id, out_q, out_r, out_error, err_count, id, exp_q, exp_r, exp_e, exp_cnt);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: ov=%b busy=%b required 0 0", nm, out_valid, busy);
        end
    endtask

    task automatic test_decode();
        run_one(0, 18'd3700, 100, 0, 0, 0, 1'b0, "exact");
        run_one(2, 18'd3701, 100, 1, 1, 1, 1'b0, "err1");
        run_one(1, 18'd262143, 7084, 35, 1, 2, 1'b0, "maxcw");
        run_one(3, 18'd0, 0, 0, 0, 2, 1'b0, "zero");
    endtask

    task automatic test_err_clr();
        run_one(0, 18'd38, 1, 1, 1, 0, 1'b1, "clr_collide");
        run_one(2, 18'd74, 2, 0, 0, 0, 1'b0, "after_clr");
    endtask

    task automatic test_round_robin();
        int g;
        int idx;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) req_codeword[i*18 +: 18] = 18'(37 * (i + 10));
        req_valid = 4'hF;
        rst = 1'b0;
        g = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++;
            if (!$onehot0(req_ready)) begin
                errors++;
                $display("FAIL rr_onehot: req_ready=%b required one-hot or zero", req_ready);
            end
            if (req_ready != 4'b0) begin
                idx = 0;
                for (int b = 0; b < 4; b++) if (req_ready[b]) idx = b;
                checks++;
                if (g > 4 || idx != exp_order[g % 5] || c != 4 * g) begin
                    errors++;
                    $display("FAIL rr_grant: grant %0d to %0d at cycle %0d required %0d at cycle %0d",
                             g, idx, c, exp_order[g % 5], 4 * g);
                end
                g++;
            end
            if (out_valid) begin
                checks++;
                if (out_q !== 13'(out_id + 10) || out_r !== 6'd0 || out_error !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_data: id=%0d q=%0d r=%0d e=%b required q=%0d r=0 e=0",
                             out_id, out_q, out_r, out_error, out_id + 10);
                end
            end
        end
        checks++;
        if (g != 5) begin
            errors++;
            $display("FAIL rr_count: grants=%0d required 5", g);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        req_codeword[18 +: 18] = 18'd3701;
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'b0001;
        @(negedge clk);
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'd1 || out_q !== 13'd100 || out_r !== 6'd1 ||
                out_error !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0 || err_count !== 16'd1) begin
                errors++;
                $display("FAIL hold_%0d: ov=%b id=%0d q=%0d r=%0d e=%b busy=%b rdy=%b cnt=%0d required 1 1 100 1 1 1 0000 1",
                         h, out_valid, out_id, out_q, out_r, out_error, busy, req_ready, err_count);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL release: ov=%b busy=%b rdy=%b required 0 0 0001", out_valid, busy, req_ready);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_rst_midflight();
        @(negedge clk);
        req_codeword[36 +: 18] = 18'd3701;
        req_codeword[0 +: 18]  = 18'd370;
        req_codeword[54 +: 18] = 18'd740;
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: busy=%b required 1", busy);
        end
        rst = 1'b1;
        req_valid = 4'b1001;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || req_ready !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b ov=%b rdy=%b required 0 0 0000", busy, out_valid, req_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ptr: req_ready=%b required 0001", req_ready);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req_valid = '0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_drop_%0d: out_valid=%b required 0", c, out_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_q !== 13'd10 || out_r !== 6'd0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_next: ov=%b id=%0d q=%0d r=%0d cnt=%0d required 1 0 10 0 0",
                     out_valid, out_id, out_q, out_r, err_count);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int exp_cnt;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            s_req_codeword[17:0] = 18'd1;
            s_req_valid = 2'b01;
            @(negedge clk);
            s_req_valid = 2'b00;
            repeat (2) @(negedge clk);
            exp_cnt = (e > 7) ? 7 : e;
            checks++;
            if (s_out_valid !== 1'b1 || s_out_error !== 1'b1 || s_err_count !== 3'(exp_cnt)) begin
                errors++;
                $display("FAIL sat_%0d: ov=%b e=%b cnt=%0d required 1 1 %0d",
                         e, s_out_valid, s_out_error, s_err_count, exp_cnt);
            end
            @(negedge clk);
        end
        s_err_clr = 1'b1;
        @(negedge clk);
        s_err_clr = 1'b0;
        checks++;
        if (s_err_count !== 3'd0) begin
            errors++;
            $display("FAIL sat_clear: cnt=%0d required 0", s_err_count);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_err_clr();
        test_round_robin();
        test_backpressure();
        test_rst_midflight();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
